// File: rtl/seg_led_out_if.sv
// rtl/seg_led_out_if.sv - CPU store-side bus into the seg_led_out peripheral
interface seg_led_out_if;
  logic        OutCtrl;
  logic        ioWrite;
  logic [2:0]  outAddr;
  logic [15:0] write_data;

  modport master (output OutCtrl, ioWrite, outAddr, write_data);
  modport slave  (input  OutCtrl, ioWrite, outAddr, write_data);
endinterface

// File: rtl/seg_led_out.sv
// rtl/seg_led_out.sv - LED register bank plus multiplexed 8-digit 7-segment driver
// Optional digit blinking is built when SEG_BLINK_EN is defined.
module seg_led_out #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic          clock,
  input  logic          reset,
  seg_led_out_if.slave  bus,
  output logic [23:0]   leds,
  output logic [7:0]    seg_en,
  output logic [7:0]    seg_out
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc;
  logic [2:0]    digit;
  logic [31:0]   disp;
  logic [7:0]    blank_mask;
  logic          wr;
  logic          tc;
  logic [2:0]    digit_next;
  logic [3:0]    nibble;
  logic          blink_hide;
  logic          hide;
  logic [7:0]    hex_seg;

  assign wr         = bus.OutCtrl & bus.ioWrite;
  assign tc         = (presc == PW'(SCAN_DIV - 1));
  assign digit_next = digit + 3'd1;
  assign nibble     = disp[{digit_next, 2'b00} +: 4];
  assign hide       = blank_mask[digit_next] | blink_hide;

  always_comb begin
    hex_seg = 8'hFF;
    case (nibble)
      4'h0: hex_seg = 8'hC0;
      4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;
      4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;
      4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;
      4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;
      4'h9: hex_seg = 8'h90;
      4'hA: hex_seg = 8'h88;
      4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;
      4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;
      default: hex_seg = 8'h8E;
    endcase
  end

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [7:0]    blink_mask;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  assign blink_hide = blink_phase & blink_mask[digit_next];

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset)
      blink_mask <= 8'h00;
    else if (wr && bus.outAddr == 3'b101)
      blink_mask <= bus.write_data[15:8];
  end
`else
  assign blink_hide = 1'b0;
`endif

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      leds       <= 24'h0;
      disp       <= 32'h0;
      blank_mask <= 8'h00;
    end else if (wr) begin
      case (bus.outAddr)
        3'b000: leds[7:0]   <= bus.write_data[7:0];
        3'b001: leds[15:8]  <= bus.write_data[7:0];
        3'b010: leds[23:16] <= bus.write_data[7:0];
        3'b011: disp[15:0]  <= bus.write_data;
        3'b100: disp[31:16] <= bus.write_data;
        3'b101: blank_mask  <= bus.write_data[7:0];
        default: ;
      endcase
    end
  end

  // Slot outputs latch only at the advance, so register writes never disturb an active slot.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      presc   <= '0;
      digit   <= 3'd7;
      seg_en  <= 8'hFF;
      seg_out <= 8'hFF;
    end else if (tc) begin
      presc   <= '0;
      digit   <= digit_next;
      seg_en  <= hide ? 8'hFF : ~(8'h01 << digit_next);
      seg_out <= hide ? 8'hFF : hex_seg;
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: tb/tb_seg_led_out.sv
// tb/tb_seg_led_out.sv - self-checking bench for seg_led_out
module tb_seg_led_out;

  localparam int SCAN  = 4;
  localparam int BLINK = 16;
`ifdef SEG_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] leds;
  logic [7:0]  seg_en;
  logic [7:0]  seg_out;

  seg_led_out_if bus ();

  seg_led_out #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .leds    (leds),
    .seg_en  (seg_en),
    .seg_out (seg_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference: slot k (k>=1) starts at falling edge k*SCAN after reset and shows digit (k-1)%8.
  int          n;
  logic [23:0] m_leds;
  logic [31:0] m_disp;
  logic [7:0]  m_blank, m_blink, m_en, m_out;

  typedef struct {
    logic        oc;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [23:0] exp_leds;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; m_leds = 0; m_disp = 0; m_blank = 0; m_blink = 0;
    m_en = 8'hFF; m_out = 8'hFF;
  endtask

  task automatic model_edge(input logic we, input logic [2:0] a, input logic [15:0] wd);
    int d, ph;
    bit hid;
    n++;
    if (n % SCAN == 0) begin
      d   = ((n / SCAN) - 1) % 8;
      ph  = ((n - 1) / BLINK) % 2;
      hid = m_blank[d] || (BLINK_ON && ph == 1 && m_blink[d]);
      m_en  = hid ? 8'hFF : ~(8'h01 << d);
      m_out = hid ? 8'hFF : hex_tab[(m_disp >> (4 * d)) & 32'hF];
    end
    if (we) begin
      case (a)
        3'd0: m_leds[7:0]   = wd[7:0];
        3'd1: m_leds[15:8]  = wd[7:0];
        3'd2: m_leds[23:16] = wd[7:0];
        3'd3: m_disp[15:0]  = wd;
        3'd4: m_disp[31:16] = wd;
        3'd5: begin
          m_blank = wd[7:0];
          if (BLINK_ON) m_blink = wd[15:8];
        end
        default: ;
      endcase
    end
  endtask

  // Called at a rising edge; drives, lets one falling edge act, checks, returns at next rising edge.
  task automatic cycle(input logic oc, input logic iw, input logic [2:0] a, input logic [15:0] wd);
    bus.OutCtrl = oc; bus.ioWrite = iw; bus.outAddr = a; bus.write_data = wd;
    @(negedge clock);
    model_edge(oc & iw, a, wd);
    #1;
    chk("leds", 32'(leds), 32'(m_leds));
    chk("seg_en", 32'(seg_en), 32'(m_en));
    chk("seg_out", 32'(seg_out), 32'(m_out));
    @(posedge clock);
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) cycle(1'b0, 1'b0, 3'd0, 16'h0);
  endtask

  task automatic release_reset();
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd1, 16'h12AB, 24'h00AB00};
    vecs[1] = '{1'b1, 3'd0, 16'h0034, 24'h00AB34};
    vecs[2] = '{1'b0, 3'd3, 16'h12AB, 24'h00AB34};
    vecs[3] = '{1'b1, 3'd2, 16'hFF77, 24'h77AB34};
    vecs[4] = '{1'b1, 3'd6, 16'hFFFF, 24'h77AB34};
    vecs[5] = '{1'b0, 3'd0, 16'h00EE, 24'h77AB34};

    bus.OutCtrl = 0; bus.ioWrite = 0; bus.outAddr = 0; bus.write_data = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_seg_en", 32'(seg_en), 32'hFF);
    chk("rst_seg_out", 32'(seg_out), 32'hFF);
    @(posedge clock);
    release_reset();

    idle(3);
    chk("pre_first_slot_en", 32'(seg_en), 32'hFF);
    idle(37);

    for (int i = 0; i < 6; i++) begin
      cycle(vecs[i].oc, 1'b1, vecs[i].addr, vecs[i].data);
      chk($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].exp_leds));
    end

    cycle(1'b1, 1'b1, 3'd3, 16'h5A3F);
    cycle(1'b1, 1'b1, 3'd4, 16'h0000);
    idle(40);
    cycle(1'b1, 1'b1, 3'd5, 16'h00F0);
    idle(40);

    // Async reset mid-slot with a write in flight: outputs drop at once, write is lost.
    idle(2);
    bus.OutCtrl = 1; bus.ioWrite = 1; bus.outAddr = 3'd0; bus.write_data = 16'h00FF;
    reset = 1'b1;
    #1;
    chk("midrst_leds", 32'(leds), 32'h0);
    chk("midrst_seg_en", 32'(seg_en), 32'hFF);
    chk("midrst_seg_out", 32'(seg_out), 32'hFF);
    @(negedge clock);
    @(posedge clock);
    bus.OutCtrl = 0; bus.ioWrite = 0;
    release_reset();

    // Write to disp on the very edge of the first advance (digit 0).
    idle(3);
    cycle(1'b1, 1'b1, 3'd3, 16'h0050);
    chk("same_edge_en", 32'(seg_en), 32'hFE);
    chk("same_edge_out_old", 32'(seg_out), 32'hC0);
    idle(4);
    chk("next_slot_en", 32'(seg_en), 32'hFD);
    chk("next_slot_out_new", 32'(seg_out), 32'h92);
    cycle(1'b1, 1'b1, 3'd3, 16'h0000);

    cycle(1'b1, 1'b1, 3'd5, 16'h0100);
    idle(96);
    cycle(1'b1, 1'b1, 3'd5, 16'h0000);

    for (int i = 0; i < 1500; i++) begin
      logic        oc, iw;
      logic [2:0]  a;
      logic [15:0] wd;
      oc = ($urandom_range(0, 3) == 0);
      iw = ($urandom_range(0, 3) != 0);
      a  = 3'($urandom_range(0, 7));
      wd = 16'($urandom);
      if (a == 3'd5) wd[7:0] = wd[7:0] & 8'($urandom);
      cycle(oc, iw, a, wd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
